// File: rtl/i2s_slave_rx_deser.sv
// i2s_slave_rx_deser
// I2S slave receive front end. Oversamples the pad-level SCK/WS/DIN on WB_CLK,
// deserialises left/right words MSB first, packs each stereo frame as {L,R}
// and buffers frames in a small first-word-fall-through FIFO.
//
// Ports
//   WB_CLK        fabric clock, at least 4x the I2S bit clock
//   WB_RSTn       asynchronous active-low reset
//   I2S_CLK_i     I2S bit clock from pad (asynchronous)
//   I2S_WS_CLK_i  word select from pad, 0 = left, 1 = right
//   I2S_DIN_i     serial data from pad
//   rx_en_i       receiver enable
//   smpl_dat_o    FIFO head, [31:16] left, [15:0] right, left-justified
//   smpl_vld_o    FIFO not empty
//   smpl_rdy_i    pops the head when smpl_vld_o is also high
//   ovfl_o        sticky overflow flag, set when a frame is dropped
//   ovfl_clr_i    one-cycle clear for ovfl_o
//   rx_debug_o    {level[3:0], empty, ovfl_o, state[1:0]}
//
// State  | meaning
// IDLE 0 | receiver disabled
// SYNC 1 | waiting for a WS 1->0 change to find the frame start
// LEFT 2 | capturing the left word
// RIGHT 3| capturing the right word, frame pushed on close
module i2s_slave_rx_deser #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        WB_CLK,
  input  logic        WB_RSTn,
  input  logic        I2S_CLK_i,
  input  logic        I2S_WS_CLK_i,
  input  logic        I2S_DIN_i,
  input  logic        rx_en_i,
  output logic [31:0] smpl_dat_o,
  output logic        smpl_vld_o,
  input  logic        smpl_rdy_i,
  output logic        ovfl_o,
  input  logic        ovfl_clr_i,
  output logic [7:0]  rx_debug_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } state_t;

  // pad synchronisers; sck_s3 is the edge-detect delay
  logic sck_s1, sck_s2, sck_s3;
  logic ws_s1, ws_s2;
  logic din_s1, din_s2;
  logic sck_rise;

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_s3 <= 1'b0;
      ws_s1  <= 1'b0;
      ws_s2  <= 1'b0;
      din_s1 <= 1'b0;
      din_s2 <= 1'b0;
    end else begin
      sck_s1 <= I2S_CLK_i;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      ws_s1  <= I2S_WS_CLK_i;
      ws_s2  <= ws_s1;
      din_s1 <= I2S_DIN_i;
      din_s2 <= din_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_s3;

  state_t                state;
  logic                  ws_prev;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]         bitcnt, bitcnt_nxt;
  logic [15:0]           word_just;
  logic [15:0]           left_q;
  logic [31:0]           frame_q;
  logic                  close_q;
  logic                  push_q;
  logic                  ws_rise, ws_fall;

  assign ws_rise = ws_s2 & ~ws_prev;
  assign ws_fall = ~ws_s2 & ws_prev;

  // Next shift value including the bit on this sck_rise; word_just left-justifies
  // the captured bits in 16, which also zero-pads short words at the LSB end.
  always_comb begin
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    if (bitcnt < CW'(DATA_WIDTH)) begin
      shreg_nxt  = {shreg[DATA_WIDTH-2:0], din_s2};
      bitcnt_nxt = bitcnt + CW'(1);
    end
    word_just = 16'(shreg_nxt) << (5'd16 - 5'(bitcnt_nxt));
  end

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      state   <= IDLE;
      ws_prev <= 1'b0;
      shreg   <= '0;
      bitcnt  <= '0;
      left_q  <= '0;
      frame_q <= '0;
      close_q <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      close_q <= 1'b0;
      push_q  <= close_q;
      if (sck_rise) ws_prev <= ws_s2;
      if (!rx_en_i) begin
        state  <= IDLE;
        shreg  <= '0;
        bitcnt <= '0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (sck_rise && ws_fall) begin
              state  <= LEFT;
              shreg  <= '0;
              bitcnt <= '0;
            end
          end
          LEFT: begin
            if (sck_rise) begin
              if (ws_rise) begin
                left_q <= word_just;
                shreg  <= '0;
                bitcnt <= '0;
                state  <= RIGHT;
              end else begin
                shreg  <= shreg_nxt;
                bitcnt <= bitcnt_nxt;
              end
            end
          end
          RIGHT: begin
            if (sck_rise) begin
              if (ws_fall) begin
                frame_q <= {left_q, word_just};
                close_q <= 1'b1;
                shreg   <= '0;
                bitcnt  <= '0;
                state   <= LEFT;
              end else begin
                shreg  <= shreg_nxt;
                bitcnt <= bitcnt_nxt;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // frame FIFO
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, push_ok, drop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = smpl_vld_o & smpl_rdy_i;
  assign push_ok = push_q & (~full | pop);
  assign drop    = push_q & full & ~pop;

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovfl_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // a drop in the same cycle as a clear keeps the flag set
      if (drop)            ovfl_o <= 1'b1;
      else if (ovfl_clr_i) ovfl_o <= 1'b0;
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (push_ok) mem[wr_ptr] <= frame_q;
  end

  assign smpl_vld_o = (level != '0);
  assign smpl_dat_o = smpl_vld_o ? mem[rd_ptr] : 32'h0;
  // bit 3 is the empty flag, so it reads 1 out of reset
  assign rx_debug_o = {4'(level), ~smpl_vld_o, ovfl_o, state};

endmodule

// File: tb/tb_i2s_slave_rx_deser.sv
module tb_i2s_slave_rx_deser;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0, ws = 1'b0, din = 1'b0;
  logic        rx_en = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic        rx_en12 = 1'b0, rdy12 = 1'b0;
  logic [31:0] dat, dat12;
  logic        vld, vld12, ovfl, ovfl12;
  logic [7:0]  dbg, dbg12;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  int pop_idx = 0;

  always #5 clk = ~clk;

  i2s_slave_rx_deser #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .WB_CLK(clk), .WB_RSTn(rst_n), .I2S_CLK_i(sck), .I2S_WS_CLK_i(ws), .I2S_DIN_i(din),
    .rx_en_i(rx_en), .smpl_dat_o(dat), .smpl_vld_o(vld), .smpl_rdy_i(rdy),
    .ovfl_o(ovfl), .ovfl_clr_i(clr), .rx_debug_o(dbg));

  i2s_slave_rx_deser #(.DATA_WIDTH(12), .FIFO_DEPTH(4)) dut12 (
    .WB_CLK(clk), .WB_RSTn(rst_n), .I2S_CLK_i(sck), .I2S_WS_CLK_i(ws), .I2S_DIN_i(din),
    .rx_en_i(rx_en12), .smpl_dat_o(dat12), .smpl_vld_o(vld12), .smpl_rdy_i(rdy12),
    .ovfl_o(ovfl12), .ovfl_clr_i(1'b0), .rx_debug_o(dbg12));

  // Model: keep the first min(nbits, dw) source bits, MSB first, left-justified in 16.
  function automatic logic [15:0] pad_word(input logic [23:0] w, input int nbits, input int dw);
    logic [15:0] r = 16'h0;
    int k = (nbits < dw) ? nbits : dw;
    for (int i = 0; i < k; i++) r[15-i] = w[nbits-1-i];
    return r;
  endfunction

  function automatic int model_level();
    return exp_q.size() - pop_idx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One SCK period of 8 WB_CLK; optional one-cycle rdy pulse on the cycle the
  // closing frame reaches the FIFO (5th WB_CLK edge after the SCK rising edge).
  task automatic sck_bit(input logic w, input logic d, input bit pulse);
    sck = 1'b0; ws = w; din = d;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (pulse) begin
      rdy = 1'b1;
      @(posedge clk);
      #1 rdy = 1'b0;
    end
  endtask

  // n bits MSB first on channel w; when close, WS flips on the last bit (I2S LSB timing)
  task automatic send_bits(input logic [23:0] data, input int n, input logic w, input bit close, input bit pulse);
    for (int i = n - 1; i >= 0; i--)
      sck_bit((close && i == 0) ? ~w : w, data[i], pulse && (i == 0));
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n, input bit pulse);
    if (rdy || pulse || model_level() < DEPTH)
      exp_q.push_back({pad_word(l, n, 16), pad_word(r, n, 16)});
    send_bits(l, n, 1'b0, 1'b1, 1'b0);
    send_bits(r, n, 1'b1, 1'b1, pulse);
  endtask

  // Every cycle: head must match the next expected frame; debug fields consistent.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (dbg[3] !== ~vld || dbg[2] !== ovfl || ((dbg[7:4] != 4'h0) !== vld)) begin
        n_errors++;
        $display("FAIL debug_fields: got dbg=%h vld=%b ovfl=%b", dbg, vld, ovfl);
      end
      if (vld) begin
        n_checks++;
        if (pop_idx >= exp_q.size()) begin
          n_errors++;
          $display("FAIL head_unexpected: got %h expected no valid frame", dat);
        end else if (dat !== exp_q[pop_idx]) begin
          n_errors++;
          $display("FAIL head_data: got %h expected %h (frame %0d)", dat, exp_q[pop_idx], pop_idx);
        end
        if (rdy) pop_idx++;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dat", dat, 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_ovfl", 32'(ovfl), 32'h0);
    chk("rst_dbg", 32'(dbg), 32'h08);
    chk("rst_dbg12", 32'(dbg12), 32'h08);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_state", 32'(dbg[1:0]), 32'd0);
    rx_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("sync_state", 32'(dbg[1:0]), 32'd1);

    chk("model_pad16", 32'(pad_word(24'hA5C3, 16, 16)), 32'hA5C3);
    chk("model_pad12", 32'(pad_word(24'hABCDEF, 24, 12)), 32'hABC0);
    chk("model_short", 32'(pad_word(24'h5, 3, 16)), 32'hA000);

    // stream starts mid-left, then a full right word: neither may be pushed
    send_bits(24'h2A, 7, 1'b0, 1'b1, 1'b0);
    send_bits(24'hDEAD, 16, 1'b1, 1'b1, 1'b0);
    send_frame(24'hA5C3, 24'h3C5A, 16, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("t1_dat", dat, 32'hA5C33C5A);
    chk("t1_vld", 32'(vld), 32'h1);
    chk("t1_level", 32'(dbg[7:4]), 32'd1);
    chk("t1_state", 32'(dbg[1:0]), 32'd2);

    rdy = 1'b1;
    send_frame(24'hFFFF, 24'h0000, 16, 1'b0);
    send_frame(24'h8001, 24'h7FFE, 16, 1'b0);
    send_frame(24'h1234, 24'hFEDC, 16, 1'b0);
    repeat (10) @(posedge clk); #1;
    chk("stream_empty", 32'(vld), 32'h0);

    // fill to depth, ninth frame dropped
    rdy = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(24'h1100 + 24'(i), 24'h2200 + 24'(i), 16, 1'b0);
    repeat (8) @(posedge clk); #1;
    chk("full_level", 32'(dbg[7:4]), 32'd8);
    chk("full_ovfl", 32'(ovfl), 32'h1);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    chk("ovfl_clr", 32'(ovfl), 32'h0);

    // full FIFO: pop in the push cycle, nothing dropped
    send_frame(24'h1110, 24'h2210, 16, 1'b1);
    repeat (8) @(posedge clk); #1;
    chk("pp_level", 32'(dbg[7:4]), 32'd8);
    chk("pp_ovfl", 32'(ovfl), 32'h0);
    rdy = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("drain_level", 32'(dbg[7:4]), 32'd0);
    chk("drain_count", 32'(pop_idx), 32'(exp_q.size()));

    // 12-bit receiver fed 24-bit words
    rx_en = 1'b0; rx_en12 = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("t5_idle16", 32'(dbg[1:0]), 32'd0);
    send_bits(24'h3, 4, 1'b1, 1'b1, 1'b0);
    send_bits(24'hABCDEF, 24, 1'b0, 1'b1, 1'b0);
    send_bits(24'hABCDEF, 24, 1'b1, 1'b1, 1'b0);
    repeat (8) @(posedge clk); #1;
    chk("t5_vld12", 32'(vld12), 32'h1);
    chk("t5_dat12", dat12, {pad_word(24'hABCDEF, 24, 12), pad_word(24'hABCDEF, 24, 12)});
    chk("t5_dat12_lit", dat12, 32'hABC0ABC0);
    chk("t5_level12", 32'(dbg12[7:4]), 32'd1);
    rx_en12 = 1'b0;

    // enable dropped mid-left word; prior FIFO content must survive
    rdy = 1'b0; rx_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    send_bits(24'h5, 3, 1'b1, 1'b1, 1'b0);
    send_frame(24'h0F0F, 24'hF0F0, 16, 1'b0);
    send_bits(24'h3F, 6, 1'b0, 1'b0, 1'b0);
    rx_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t6_idle", 32'(dbg[1:0]), 32'd0);
    rx_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("t6_sync", 32'(dbg[1:0]), 32'd1);
    send_bits(24'h3FF, 10, 1'b0, 1'b1, 1'b0);
    send_bits(24'hBEEF, 16, 1'b1, 1'b1, 1'b0);
    send_frame(24'h1357, 24'h2468, 16, 1'b0);
    repeat (8) @(posedge clk); #1;
    chk("t6_level", 32'(dbg[7:4]), 32'd2);
    chk("t6_head", dat, 32'h0F0FF0F0);

    // asynchronous reset mid-frame
    send_bits(24'hAAAA, 8, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dat", dat, 32'h0);
    chk("arst_vld", 32'(vld), 32'h0);
    chk("arst_ovfl", 32'(ovfl), 32'h0);
    chk("arst_dbg", 32'(dbg), 32'h08);
    chk("arst_dat12", dat12, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
